async_fifo_param: RTL and testbench
===================================

Name: async_fifo_param

Overview:
- Parametrised dual-clock FIFO: the next-generation successor to the fixed 8-bit, 16-deep async FIFO.
- Moves DATA_W-bit words from the wclk domain to the rclk domain using Gray-coded pointers and SYNC_STAGES-deep synchronisers.
- Adds registered almost-full/almost-empty flags, fill-level outputs in both domains, sticky overflow/underflow error flags, and a selectable read mode (first-word-fall-through or registered).
- Sits between a producer and a consumer on unrelated clocks.

Parameters:
DATA_W, 8, word width in bits (>=1)
DEPTH, 16, number of entries; power of 2, >=4; ADDR_W = log2(DEPTH)
SYNC_STAGES, 2, flops per pointer synchroniser (2..4)
AF_THRESH, DEPTH-2, walmost_full asserts when wlevel >= AF_THRESH
AE_THRESH, 2, ralmost_empty asserts when rlevel <= AE_THRESH
FWFT, 1, 1 = show-ahead rdata; 0 = registered rdata, one rclk after pop

Ports:
wclk  in  1  write clock
wrst_n  in  1  write-domain reset; synchronous, active-low
rclk  in  1  read clock
rrst_n  in  1  read-domain reset; synchronous to rclk, active-low
winc  in  1  push request
wdata  in  DATA_W  push data
wfull  out  1  FIFO full (write domain)
walmost_full  out  1  level >= AF_THRESH
wlevel  out  ADDR_W+1  write-side occupancy, 0..DEPTH
woverflow  out  1  sticky: push attempted while full
rinc  in  1  pop request
rdata  out  DATA_W  read data
rempty  out  1  FIFO empty (read domain)
ralmost_empty  out  1  level <= AE_THRESH
rlevel  out  ADDR_W+1  read-side occupancy, 0..DEPTH
runderflow  out  1  sticky: pop attempted while empty

Behaviour:
- Reset: reset wrst_n, synchronous, active-low; clock wclk. While wrst_n=0 at posedge wclk: wptr=0, write-side synchroniser chain cleared, wfull=0, walmost_full=0, wlevel=0, woverflow=0.
- rrst_n likewise resets the read domain at posedge rclk: rptr=0, rempty=1, ralmost_empty=1, rlevel=0, runderflow=0, rdata=0 when FWFT=0.
- Memory contents are not reset.
- A full flush requires both resets to overlap for >= SYNC_STAGES+1 edges of the slower clock. Asserting a single reset mid-operation is unsupported and leaves flags undefined until both domains have been reset.
- Pointers: (ADDR_W+1)-bit binary plus Gray registers. Only Gray values cross domains. The MSB distinguishes wrap laps.
- Push accepted iff winc=1 and wfull=0 at posedge wclk: mem[wptr[ADDR_W-1:0]] <= wdata, wptr increments.
- winc=1 with wfull=1: no write, pointer unchanged, woverflow <= 1 (held until wrst_n).
- Pop accepted iff rinc=1 and rempty=0 at posedge rclk: rptr increments.
- rinc=1 with rempty=1: no change, runderflow <= 1 (held until rrst_n).
- FWFT=1: rdata = mem[rptr] continuously, valid whenever rempty=0. The value sampled at the popping edge is the popped word.
- FWFT=0: rdata is registered on an accepted pop and valid from the next posedge rclk. rdata holds otherwise.
- wfull is registered. It asserts at the same wclk edge as the push that makes next wgray equal the synced rgray with its top 2 bits inverted.
- rempty is registered. It asserts at the rclk edge of the pop that makes next rgray equal the synced wgray.
- Latency: after a push, rempty deasserts SYNC_STAGES+1 rclk edges later. After a pop, wfull deasserts SYNC_STAGES+1 wclk edges later.
- Flags are pessimistic: full/almost_full may linger, empty/almost_empty may linger. They are never optimistic.
- wlevel = next wptr - bin(synced rptr), registered, modulo 2^(ADDR_W+1). It can over-estimate, never under-estimate; wlevel = DEPTH exactly when wfull.
- rlevel = bin(synced wptr) - next rptr, registered. It can under-estimate, never over-estimate; rlevel = 0 exactly when rempty.
- walmost_full and ralmost_empty are registered comparisons of the next level values.
- Simultaneous push and pop (different clocks) are independent. Occupancy is conserved, and pointer wrap past DEPTH-1 is transparent.

Test Plan:
- Reset: hold both resets 10 cycles, DATA_W=8, DEPTH=16 -> rempty=1, ralmost_empty=1, wfull=0, wlevel=0, rlevel=0, both error flags 0.
- Fill: wclk 4x rclk, push 0x01..0x10 with no reads -> walmost_full rises at the 14th push, wfull at the 16th, wlevel=16. A 17th push of 0xFF sets woverflow=1 and leaves contents unchanged.
- Drain: pop 16 times -> rdata 0x01..0x10 in order (FWFT=1 same edge; FWFT=0 one rclk later). rempty=1 after the 16th pop. A 17th pop sets runderflow=1.
- Latency: single push 0xA5 into empty FIFO -> rempty falls exactly SYNC_STAGES+1 rclk edges after the push edge; rlevel=1.
- Wrap and concurrency: 200 random pushes/pops, rclk 2.5x wclk, scoreboard against a golden queue -> zero data mismatches, no flag optimistic versus the golden occupancy, multiple pointer wraps.
- Mid-run flush: with 7 entries stored, assert both resets for 8 slow-clock cycles -> all outputs return to reset values. The next push 0x3C is popped as 0x3C.

Source files
------------

// File: rtl/async_fifo_param.sv
// Dual-clock Gray-pointer FIFO with level/threshold flags and sticky error bits.
// Latency: SYNC_STAGES+1 edges across domains; backpressure via wfull/rempty (blocked requests set woverflow/runderflow).
module async_fifo_param #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = DEPTH - 2,
    parameter int AE_THRESH   = 2,
    parameter int FWFT        = 1,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic              wclk,
    input  logic              wrst_n,
    input  logic              rclk,
    input  logic              rrst_n,
    input  logic              winc,
    input  logic [DATA_W-1:0] wdata,
    output logic              wfull,
    output logic              walmost_full,
    output logic [ADDR_W:0]   wlevel,
    output logic              woverflow,
    input  logic              rinc,
    output logic [DATA_W-1:0] rdata,
    output logic              rempty,
    output logic              ralmost_empty,
    output logic [ADDR_W:0]   rlevel,
    output logic              runderflow
);

    localparam logic [ADDR_W:0] AF_L = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0] AE_L = (ADDR_W+1)'(AE_THRESH);

    function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
        logic [ADDR_W:0] b;
        b[ADDR_W] = g[ADDR_W];
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    // ---------------- write domain ----------------
    logic [ADDR_W:0] wbin_q, wbin_d, wgray_q, wgray_d;
    logic [ADDR_W:0] wlevel_q, wlevel_d;
    logic [ADDR_W:0] rsync_q [SYNC_STAGES];
    logic [ADDR_W:0] rgray_s, rbin_s;
    logic            wpush, wfull_q, wfull_d, waf_q, waf_d, wovf_q, wovf_d;

    logic [ADDR_W:0] rbin_q, rgray_q;

    assign wpush   = winc & ~wfull_q;
    assign rgray_s = rsync_q[SYNC_STAGES-1];

    always_comb begin
        wbin_d   = wbin_q + {{ADDR_W{1'b0}}, wpush};
        wgray_d  = bin2gray(wbin_d);
        rbin_s   = gray2bin(rgray_s);
        // Full when the write pointer is exactly one lap ahead of the read pointer.
        wfull_d  = (wgray_d == {~rgray_s[ADDR_W -: 2], rgray_s[ADDR_W-2:0]});
        wlevel_d = wbin_d - rbin_s;
        waf_d    = (wlevel_d >= AF_L);
        wovf_d   = wovf_q | (winc & wfull_q);
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wbin_q   <= '0;
            wgray_q  <= '0;
            wfull_q  <= 1'b0;
            waf_q    <= 1'b0;
            wlevel_q <= '0;
            wovf_q   <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                rsync_q[i] <= '0;
            end
        end else begin
            wbin_q   <= wbin_d;
            wgray_q  <= wgray_d;
            wfull_q  <= wfull_d;
            waf_q    <= waf_d;
            wlevel_q <= wlevel_d;
            wovf_q   <= wovf_d;
            rsync_q[0] <= rgray_q;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                rsync_q[i] <= rsync_q[i-1];
            end
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst_n && wpush) begin
            mem[wbin_q[ADDR_W-1:0]] <= wdata;
        end
    end

    assign wfull        = wfull_q;
    assign walmost_full = waf_q;
    assign wlevel       = wlevel_q;
    assign woverflow    = wovf_q;

    // ---------------- read domain ----------------
    logic [ADDR_W:0] rbin_d, rgray_d;
    logic [ADDR_W:0] rlevel_q, rlevel_d;
    logic [ADDR_W:0] wsync_q [SYNC_STAGES];
    logic [ADDR_W:0] wgray_s, wbin_s;
    logic            rpop, rempty_q, rempty_d, rae_q, rae_d, runf_q, runf_d;

    assign rpop    = rinc & ~rempty_q;
    assign wgray_s = wsync_q[SYNC_STAGES-1];

    always_comb begin
        rbin_d   = rbin_q + {{ADDR_W{1'b0}}, rpop};
        rgray_d  = bin2gray(rbin_d);
        wbin_s   = gray2bin(wgray_s);
        rempty_d = (rgray_d == wgray_s);
        rlevel_d = wbin_s - rbin_d;
        rae_d    = (rlevel_d <= AE_L);
        runf_d   = runf_q | (rinc & rempty_q);
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            rbin_q   <= '0;
            rgray_q  <= '0;
            rempty_q <= 1'b1;
            rae_q    <= 1'b1;
            rlevel_q <= '0;
            runf_q   <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                wsync_q[i] <= '0;
            end
        end else begin
            rbin_q   <= rbin_d;
            rgray_q  <= rgray_d;
            rempty_q <= rempty_d;
            rae_q    <= rae_d;
            rlevel_q <= rlevel_d;
            runf_q   <= runf_d;
            wsync_q[0] <= wgray_q;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                wsync_q[i] <= wsync_q[i-1];
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata = mem[rbin_q[ADDR_W-1:0]];
        end else begin : g_reg
            logic [DATA_W-1:0] rdata_q;
            always_ff @(posedge rclk) begin
                if (!rrst_n) begin
                    rdata_q <= '0;
                end else if (rpop) begin
                    rdata_q <= mem[rbin_q[ADDR_W-1:0]];
                end
            end
            assign rdata = rdata_q;
        end
    endgenerate

    assign rempty        = rempty_q;
    assign ralmost_empty = rae_q;
    assign rlevel        = rlevel_q;
    assign runderflow    = runf_q;

endmodule

// File: tb/tb_async_fifo_param.sv
// Bench for async_fifo_param: show-ahead and registered-read instances share stimulus; queue scoreboard checks data and flag pessimism.
module tb_async_fifo_param;

    localparam int DEPTH = 16;

    logic       wclk = 1'b0, rclk = 1'b0;
    logic       wrst_n = 1'b0, rrst_n = 1'b0;
    logic       winc = 1'b0, rinc = 1'b0;
    logic [7:0] wdata = 8'h00;

    logic       wfull_f, waf_f, wovf_f, rempty_f, rae_f, runf_f;
    logic [4:0] wlevel_f, rlevel_f;
    logic [7:0] rdata_f;
    logic       wfull_r, waf_r, wovf_r, rempty_r, rae_r, runf_r;
    logic [4:0] wlevel_r, rlevel_r;
    logic [7:0] rdata_r;

    int wh = 5;
    int rh = 20;

    int errors = 0;
    int checks = 0;
    int n_acc  = 0;

    logic [7:0] exp_q[$];
    logic [7:0] pend_dat = 8'h00;
    bit         pend_vld = 1'b0;

    async_fifo_param #(.FWFT(1)) u_f (
        .wclk(wclk), .wrst_n(wrst_n), .rclk(rclk), .rrst_n(rrst_n),
        .winc(winc), .wdata(wdata), .wfull(wfull_f), .walmost_full(waf_f),
        .wlevel(wlevel_f), .woverflow(wovf_f), .rinc(rinc), .rdata(rdata_f),
        .rempty(rempty_f), .ralmost_empty(rae_f), .rlevel(rlevel_f), .runderflow(runf_f)
    );

    async_fifo_param #(.FWFT(0)) u_r (
        .wclk(wclk), .wrst_n(wrst_n), .rclk(rclk), .rrst_n(rrst_n),
        .winc(winc), .wdata(wdata), .wfull(wfull_r), .walmost_full(waf_r),
        .wlevel(wlevel_r), .woverflow(wovf_r), .rinc(rinc), .rdata(rdata_r),
        .rempty(rempty_r), .ralmost_empty(rae_r), .rlevel(rlevel_r), .runderflow(runf_r)
    );

    always #(wh) wclk = ~wclk;
    initial begin
        #3;
        forever #(rh) rclk = ~rclk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time limit, expected finish");
        $fatal(1, "watchdog timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Write-side monitor: records accepted pushes and checks write flags are never optimistic.
    always @(negedge wclk) begin
        if (wrst_n && winc) begin
            chk("wfull_implies_level", int'(!wfull_f || wlevel_f == 5'd16), 1);
            chk("wlevel_pessimistic", int'(int'(wlevel_f) >= exp_q.size()), 1);
            chk("wflags_match", int'({wfull_r, waf_r, wlevel_r}), int'({wfull_f, waf_f, wlevel_f}));
            if (!wfull_f) begin
                exp_q.push_back(wdata);
                n_acc++;
            end
        end
    end

    // Read-side monitor: pops the scoreboard on every accepted pop.
    always @(negedge rclk) begin
        if (rrst_n) begin
            if (pend_vld) begin
                chk("rdata_registered", int'(rdata_r), int'(pend_dat));
                pend_vld = 1'b0;
            end
            if (rinc) begin
                chk("rempty_implies_level", int'(!rempty_f || rlevel_f == 5'd0), 1);
                chk("rlevel_pessimistic", int'(int'(rlevel_f) <= exp_q.size()), 1);
                chk("rempty_pessimistic", int'(rempty_f || exp_q.size() > 0), 1);
                if (!rempty_f && exp_q.size() > 0) begin
                    pend_dat = exp_q.pop_front();
                    chk("rdata_fwft", int'(rdata_f), int'(pend_dat));
                    pend_vld = 1'b1;
                end
            end
        end
    end

    task automatic wr(input logic [7:0] d);
        winc  = 1'b1;
        wdata = d;
        @(posedge wclk);
        #1;
        winc = 1'b0;
    endtask

    task automatic rd();
        rinc = 1'b1;
        @(posedge rclk);
        #1;
        rinc = 1'b0;
    endtask

    task automatic wait_nonempty(input string name);
        int n;
        n = 0;
        @(posedge rclk);
        #1;
        while (rempty_f && n < 200) begin
            @(posedge rclk);
            #1;
            n++;
        end
        chk(name, int'(rempty_f), 0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_wfull"}, int'(wfull_f), 0);
        chk({tag, "_walmost_full"}, int'(waf_f), 0);
        chk({tag, "_wlevel"}, int'(wlevel_f), 0);
        chk({tag, "_woverflow"}, int'(wovf_f), 0);
        chk({tag, "_rempty"}, int'(rempty_f), 1);
        chk({tag, "_ralmost_empty"}, int'(rae_f), 1);
        chk({tag, "_rlevel"}, int'(rlevel_f), 0);
        chk({tag, "_runderflow"}, int'(runf_f), 0);
        chk({tag, "_rdata_reg"}, int'(rdata_r), 0);
    endtask

    initial begin
        int n;
        int acc0;
        bit wdone;

        // Reset: rclk (period 40) is the slow clock here.
        repeat (10) @(posedge rclk);
        #1;
        check_reset("rst");
        wrst_n = 1'b1;
        rrst_n = 1'b1;

        // Fill 0x01..0x10 with no reads, then one overflowing push.
        @(posedge wclk);
        #1;
        for (int k = 1; k <= DEPTH; k++) begin
            wr(8'(k));
            chk($sformatf("fill_wlevel_%0d", k), int'(wlevel_f), k);
            chk($sformatf("fill_almost_full_%0d", k), int'(waf_f), int'(k >= 14));
            chk($sformatf("fill_wfull_%0d", k), int'(wfull_f), int'(k == DEPTH));
        end
        chk("pre_overflow", int'(wovf_f), 0);
        wr(8'hFF);
        chk("overflow_sticky", int'(wovf_f), 1);
        chk("overflow_wlevel", int'(wlevel_f), DEPTH);

        // Let the write pointer settle into the read domain, then drain.
        repeat (10) @(posedge rclk);
        #1;
        chk("settled_rlevel", int'(rlevel_f), DEPTH);
        chk("settled_rempty", int'(rempty_f), 0);
        chk("settled_ralmost_empty", int'(rae_f), 0);
        for (int k = 1; k <= DEPTH; k++) begin
            rd();
            chk($sformatf("drain_rlevel_%0d", k), int'(rlevel_f), DEPTH - k);
            chk($sformatf("drain_almost_empty_%0d", k), int'(rae_f), int'(DEPTH - k <= 2));
            chk($sformatf("drain_rempty_%0d", k), int'(rempty_f), int'(k == DEPTH));
        end
        chk("pre_underflow", int'(runf_f), 0);
        rd();
        chk("underflow_sticky", int'(runf_f), 1);
        chk("underflow_rempty", int'(rempty_f), 1);
        repeat (5) @(posedge rclk);
        #1;
        chk("drained_wfull", int'(wfull_f), 0);
        chk("drained_wlevel", int'(wlevel_f), 0);
        chk("drained_walmost_full", int'(waf_f), 0);
        chk("scoreboard_empty_after_drain", exp_q.size(), 0);

        // Latency: single push into an empty FIFO.
        @(posedge wclk);
        #1;
        wr(8'hA5);
        n = 0;
        while (n < 20) begin
            @(posedge rclk);
            n++;
            #1;
            if (!rempty_f) break;
        end
        chk("latency_edges", n, 3);
        chk("latency_rlevel", int'(rlevel_f), 1);
        rd();
        chk("latency_pop_rempty", int'(rempty_f), 1);

        // Random concurrent traffic with rclk 2.5x wclk.
        wh = 10;
        rh = 4;
        repeat (4) @(posedge wclk);
        acc0  = n_acc;
        wdone = 1'b0;
        fork
            begin
                for (int i = 0; i < 250; i++) begin
                    @(posedge wclk);
                    #1;
                    winc  = ($urandom_range(0, 99) < 70);
                    wdata = 8'($urandom);
                end
                @(posedge wclk);
                #1;
                winc  = 1'b0;
                wdone = 1'b1;
            end
            begin
                while (!wdone) begin
                    @(posedge rclk);
                    #1;
                    rinc = ($urandom_range(0, 99) < 30);
                end
            end
        join
        n    = 0;
        rinc = 1'b1;
        while (exp_q.size() > 0 && n < 2000) begin
            @(posedge rclk);
            #1;
            n++;
        end
        rinc = 1'b0;
        chk("random_drain_complete", exp_q.size(), 0);
        chk("random_multiple_wraps", int'((n_acc - acc0) > 2 * DEPTH), 1);
        repeat (4) @(posedge rclk);
        #1;
        chk("random_end_rempty", int'(rempty_f), 1);

        // Mid-run flush with 7 entries stored; wclk is now the slow clock.
        @(posedge wclk);
        #1;
        for (int i = 0; i < 7; i++) begin
            wr(8'h40 + 8'(i));
        end
        repeat (10) @(posedge rclk);
        #1;
        chk("flush_pre_rlevel", int'(rlevel_f), 7);
        @(posedge wclk);
        #1;
        wrst_n = 1'b0;
        rrst_n = 1'b0;
        repeat (8) @(posedge wclk);
        #1;
        exp_q.delete();
        pend_vld = 1'b0;
        check_reset("flush");
        wrst_n = 1'b1;
        rrst_n = 1'b1;
        @(posedge wclk);
        #1;
        wr(8'h3C);
        wait_nonempty("flush_push_visible");
        chk("flush_rlevel", int'(rlevel_f), 1);
        rd();
        repeat (2) @(posedge rclk);
        #1;
        chk("flush_scoreboard_consumed", exp_q.size(), 0);
        chk("flush_final_rempty", int'(rempty_f), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
